// File: rtl/hazard_control_unit.sv
// ----------------------------------------------------------------------------
// hazard_control_unit
//
// Purpose:
//   Pipeline hazard controller that sits beside the decode stage. It produces
//   the STALL and DUMP controls for the Fetch/Decode and Decode/Execute
//   moderators, and the PC hold / redirect controls for the PC register.
//
//   Two situations are handled:
//     * Read-after-write hazards: the instruction in Decode reads a register
//       that an older instruction still in Execute or Memory will write.
//       Decode is held (STALL_FD, PC_hold) and a bubble enters Execute
//       (DUMP_DE).
//     * Taken branches: when Execute resolves a taken branch or jump, the
//       wrong-path instructions are squashed for FLUSH_CYCLES cycles
//       (DUMP_FD, DUMP_DE). The PC is redirected one cycle later from a
//       registered copy of the target.
//
//   A shadow scoreboard tracks what the Execute and Memory stages hold, so
//   the decoder does not have to feed back pipeline state.
//
// Parameters:
//   FORWARDING   1 = bypass network present, only a load in Execute stalls;
//                0 = any in-flight writer in Execute or Memory stalls.
//   FLUSH_CYCLES cycles of DUMP_FD per taken branch, including the resolve
//                cycle. Legal range 1..4.
//   CNT_W        width of the saturating performance counters.
//
// Ports:
//   clock                   in   pipeline clock, rising edge
//   reset                   in   synchronous, active-high
//   rs1_Decode / rs2_Decode in   source registers of the Decode instruction
//   rs1_used / rs2_used     in   the Decode instruction reads rs1 / rs2
//   reg_wEn_Decode          in   the Decode instruction writes a register
//   writeback_Reg_Decode    in   destination register of the Decode instr.
//   mem_read_Decode         in   the Decode instruction is a load
//   next_PC_select_Execute  in   taken branch/jump resolved in Execute
//   target_PC_Execute       in   redirect target
//   STALL_FD                out  hold the Fetch/Decode moderator
//   PC_hold                 out  hold the PC register (same as STALL_FD)
//   DUMP_FD                 out  bubble into the Fetch/Decode moderator
//   DUMP_DE                 out  bubble into the Decode/Execute moderator
//   redirect_valid          out  PC loads redirect_PC this cycle
//   redirect_PC             out  registered copy of target_PC_Execute
//   stall_count             out  hazard-stall cycles, saturating
//   flush_count             out  taken-branch flushes, saturating
// ----------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int unsigned FORWARDING   = 0,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,

    input  logic [4:0]       rs1_Decode,
    input  logic [4:0]       rs2_Decode,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic             reg_wEn_Decode,
    input  logic [4:0]       writeback_Reg_Decode,
    input  logic             mem_read_Decode,

    input  logic             next_PC_select_Execute,
    input  logic [15:0]      target_PC_Execute,

    output logic             STALL_FD,
    output logic             PC_hold,
    output logic             DUMP_FD,
    output logic             DUMP_DE,
    output logic             redirect_valid,
    output logic [15:0]      redirect_PC,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Remaining flush cycles after the resolve cycle; at most 3.
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t     state;
    logic [1:0] flush_left;
    logic       redirect_q;

    // Shadow scoreboard: does Decode hold a real instruction, and what are
    // the writers currently in Execute and Memory.
    logic       dec_valid;
    logic       ex_v;
    logic [4:0] ex_rd;
    logic       ex_load;
    logic       mem_v;
    logic [4:0] mem_rd;

    // ------------------------------------------------------------------------
    // Combinational next-state / control
    // ------------------------------------------------------------------------
    state_t     state_next;
    logic [1:0] flush_left_next;
    logic       take_branch;
    logic       count_stall;

    logic       rs1_live;
    logic       rs2_live;
    logic       hit_ex;
    logic       hit_mem;
    logic       hazard;

    // A source is only compared when the instruction is real, actually reads
    // the register, and the register is not x0 (x0 is never written).
    assign rs1_live = dec_valid && rs1_used && (rs1_Decode != 5'd0);
    assign rs2_live = dec_valid && rs2_used && (rs2_Decode != 5'd0);

    assign hit_ex  = ex_v  && ((rs1_live && (rs1_Decode == ex_rd)) ||
                               (rs2_live && (rs2_Decode == ex_rd)));
    assign hit_mem = mem_v && ((rs1_live && (rs1_Decode == mem_rd)) ||
                               (rs2_live && (rs2_Decode == mem_rd)));

    // With bypassing, ALU results in Execute/Memory are forwarded; only a
    // load in Execute has no data yet. Writeback is never compared because
    // the register file writes before it reads.
    always_comb begin
        if (FORWARDING != 0) begin
            hazard = hit_ex && ex_load;
        end else begin
            hazard = hit_ex || hit_mem;
        end
    end

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        STALL_FD        = 1'b0;
        DUMP_FD         = 1'b0;
        DUMP_DE         = 1'b0;
        state_next      = state;
        flush_left_next = flush_left;
        take_branch     = 1'b0;
        count_stall     = 1'b0;

        if (reset) begin
            // Squash both moderators while the pipeline is being reset.
            DUMP_FD = 1'b1;
            DUMP_DE = 1'b1;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (next_PC_select_Execute) begin
                        // A taken branch beats a hazard: the stalled Decode
                        // instruction is on the wrong path anyway.
                        DUMP_FD         = 1'b1;
                        DUMP_DE         = 1'b1;
                        take_branch     = 1'b1;
                        flush_left_next = FLUSH_RELOAD;
                        if (FLUSH_RELOAD != 2'd0) begin
                            state_next = ST_FLUSH;
                        end
                    end else if (hazard) begin
                        STALL_FD    = 1'b1;
                        DUMP_DE     = 1'b1;
                        count_stall = 1'b1;
                    end
                end

                ST_FLUSH: begin
                    // Execute only holds bubbles here, so both the hazard
                    // check and a branch indication are ignored.
                    DUMP_FD         = 1'b1;
                    DUMP_DE         = 1'b1;
                    flush_left_next = flush_left - 2'd1;
                    if (flush_left <= 2'd1) begin
                        flush_left_next = 2'd0;
                        state_next      = ST_RUN;
                    end
                end

                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    assign PC_hold        = STALL_FD;
    // The registered redirect is suppressed while reset is asserted, so a
    // reset arriving right after a resolve aborts the redirect immediately.
    assign redirect_valid = redirect_q && !reset;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of its inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            // The destination fields are cleared too, so the scoreboard never
            // holds stale register numbers after reset.
            state       <= ST_RUN;
            flush_left  <= 2'd0;
            redirect_q  <= 1'b0;
            redirect_PC <= 16'h0000;
            dec_valid   <= 1'b0;
            ex_v        <= 1'b0;
            ex_rd       <= 5'd0;
            ex_load     <= 1'b0;
            mem_v       <= 1'b0;
            mem_rd      <= 5'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state      <= state_next;
            flush_left <= flush_left_next;
            redirect_q <= take_branch;
            if (take_branch) begin
                redirect_PC <= target_PC_Execute;
            end

            // Memory takes whatever Execute held this cycle.
            mem_v  <= ex_v;
            mem_rd <= ex_rd;

            // Execute receives the Decode instruction unless a bubble is
            // injected.
            if (DUMP_DE) begin
                ex_v    <= 1'b0;
                ex_rd   <= 5'd0;
                ex_load <= 1'b0;
            end else begin
                ex_v    <= dec_valid && reg_wEn_Decode;
                ex_rd   <= writeback_Reg_Decode;
                ex_load <= mem_read_Decode;
            end

            // Decode keeps its instruction on a stall, is squashed on a dump,
            // and otherwise receives a fresh instruction from Fetch.
            if (STALL_FD) begin
                dec_valid <= dec_valid;
            end else if (DUMP_FD) begin
                dec_valid <= 1'b0;
            end else begin
                dec_valid <= 1'b1;
            end

            // Saturating counters: they stick at all-ones instead of wrapping.
            if (count_stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (take_branch && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Generates the STALL and DUMP controls for the Fetch/Decode and Decode/Execute moderators.
- Handles two cases: it detects read-after-write hazards against in-flight writers, and it flushes wrong-path instructions after a taken branch resolves in Execute.
- Keeps a shadow scoreboard of the Execute and Memory stages, a flush state machine and performance counters.
- Sits beside the decode stage. Inputs come from the decoder and the execute stage; outputs drive the pipeline moderators and the PC register.

Parameters:
- FORWARDING, 0, 1 = bypass network present, so only a load in Execute causes a hazard; 0 = any writer in Execute or Memory causes a hazard.
- FLUSH_CYCLES, 2, cycles of DUMP_FD asserted per taken branch, counting the resolve cycle (legal values 1..4).
- CNT_W, 16, width of the performance counters.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- rs1_Decode  in  5  source register 1 of the instruction in Decode.
- rs2_Decode  in  5  source register 2 of the instruction in Decode.
- rs1_used  in  1  instruction reads rs1.
- rs2_used  in  1  instruction reads rs2.
- reg_wEn_Decode  in  1  instruction in Decode writes a register.
- writeback_Reg_Decode  in  5  destination register of the instruction in Decode.
- mem_read_Decode  in  1  instruction in Decode is a load.
- next_PC_select_Execute  in  1  taken branch or jump resolved in Execute this cycle.
- target_PC_Execute  in  16  redirect target.
- STALL_FD  out  1  hold the Fetch/Decode moderator.
- PC_hold  out  1  hold the PC register; always equals STALL_FD.
- DUMP_FD  out  1  load a bubble into the Fetch/Decode moderator.
- DUMP_DE  out  1  load a bubble into the Decode/Execute moderator.
- redirect_valid  out  1  PC loads redirect_PC.
- redirect_PC  out  16  registered copy of target_PC_Execute.
- stall_count  out  CNT_W  total hazard-stall cycles, saturating.
- flush_count  out  CNT_W  total taken-branch flushes, saturating.

Behaviour:
- All of STALL_FD, DUMP_FD and DUMP_DE are combinational from the current inputs and registered state. The moderators sample them at the same clock edge.
- Internal state:
  - dec_valid
  - ex_v, ex_rd, ex_load
  - mem_v, mem_rd
  - FSM state: RUN or FLUSH
  - flush_left
  - the two counters
- Reset:
  - While reset is high: DUMP_FD=1, DUMP_DE=1, STALL_FD=0, redirect_valid=0.
  - At the edge: dec_valid=0, ex_v=0, mem_v=0, state=RUN, counters=0, redirect_PC=0.
- Hazard detection (the hazard signal):
  - A source matches when it is dec_valid, its *_used bit is set, it is nonzero, and it equals ex_rd (with ex_v) or mem_rd (with mem_v).
  - FORWARDING=0: any match is a hazard.
  - FORWARDING=1: only a match on ex_rd with ex_load=1 is a hazard.
  - Register x0 never matches.
  - The register file writes before it reads, so the Writeback stage is never compared.
- Hazard response: STALL_FD=1 and DUMP_DE=1. The Decode instruction is held and a bubble enters Execute. stall_count increments.
- Taken branch (next_PC_select_Execute=1 in state RUN) has priority over a hazard:
  - DUMP_FD=1, DUMP_DE=1, STALL_FD=0.
  - At the edge: redirect_PC <= target, redirect_valid <= 1 for exactly one cycle, flush_count increments, flush_left <= FLUSH_CYCLES-1.
  - If flush_left would be nonzero, state <= FLUSH.
- FLUSH state:
  - DUMP_FD=1, DUMP_DE=1, STALL_FD=0; hazard detection is masked.
  - flush_left decrements each cycle; the FSM returns to RUN when it reaches 0.
  - next_PC_select_Execute is ignored, since Execute holds only bubbles.
- Shadow update at every edge (when not in reset):
  - mem <= ex.
  - ex <= bubble if DUMP_DE; otherwise {dec_valid & reg_wEn_Decode, writeback_Reg_Decode, mem_read_Decode}.
  - dec_valid <= dec_valid if STALL_FD; 0 if DUMP_FD; otherwise 1.
- Counters saturate at all-ones with no wrap.
- A reset asserted mid-stall or mid-flush aborts the operation immediately; the reset values above apply at the next edge.

Test Plan:
- Reset held 3 cycles, then released -> DUMP_FD=DUMP_DE=1 throughout reset; cycle after release: all STALL/DUMP outputs 0, counters 0.
- FORWARDING=0: "add x5" in Decode, next instruction reads rs1=x5 -> STALL_FD=DUMP_DE=1 for 2 cycles (while x5 is in Execute and then Memory), stall_count=2, then the instruction issues.
- FORWARDING=1: load to x7 followed by a reader of x7 -> exactly 1 stall cycle; an ALU writer of x7 followed by a reader -> 0 stalls.
- Reader of x0 after a writer of x0 -> no stall.
- Taken branch with target 0x0040, FLUSH_CYCLES=2 -> resolve cycle: DUMP_FD=DUMP_DE=1; next cycle: redirect_valid=1, redirect_PC=0x0040, DUMP_FD=DUMP_DE=1; then RUN. flush_count=1.
- Hazard and taken branch in the same cycle -> branch wins: STALL_FD=0, stall_count unchanged. Separately, force stall_count to all-ones -> it stays at 0xFFFF.
